// File: rtl/pkg_system_mdr.sv
// Shared MDR system types: operation select encoding, one-hot op constants and
// the dispatcher state encoding.
package pkg_system_mdr;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_DIV  = 2'd1,
        OP_ROOT = 2'd2,
        OP_NON  = 2'd3
    } op_select_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE,
        ERROR
    } dispatch_state_t;

    localparam logic [3:0] OH_MULT = 4'b0001;
    localparam logic [3:0] OH_DIV  = 4'b0010;
    localparam logic [3:0] OH_ROOT = 4'b0100;
    localparam logic [3:0] OH_NON  = 4'b1000;

endpackage

// File: rtl/onehot_op_decoder.sv
// Decodes the 4-bit one-hot operation bus into op_select_t; legal is set only
// when exactly one bit is asserted.
module onehot_op_decoder
    import pkg_system_mdr::*;
(
    input  logic [3:0] onehot,
    output op_select_t op,
    output logic       legal
);

    // NOTE: every output gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        op    = OP_NON;
        legal = 1'b1;
        case (onehot)
            OH_MULT: op = OP_MULT;
            OH_DIV:  op = OP_DIV;
            OH_ROOT: op = OP_ROOT;
            OH_NON:  op = OP_NON;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/op_dispatcher.sv
// Consumer of the one-hot op bus: launches one MDR unit (or passes X through for
// NON), waits for its done and returns the result. Optional WAIT watchdog is
// enabled by defining OP_DISPATCH_TIMEOUT_EN.
module op_dispatcher
    import pkg_system_mdr::*;
#(
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_data_x,
    input  logic [DW-1:0] i_data_y,
    output logic [2:0]    o_unit_start,
    output logic [DW-1:0] o_unit_x,
    output logic [DW-1:0] o_unit_y,
    input  logic [2:0]    i_unit_done,
    input  logic [DW-1:0] i_mult_result,
    input  logic [DW-1:0] i_div_result,
    input  logic [DW-1:0] i_root_result,
    output logic [DW-1:0] o_result,
    output op_select_t    o_op,
    output logic          o_valid,
    output logic          o_error,
    output logic          o_busy
);

    dispatch_state_t state, next_state;
    op_select_t      dec_op;
    logic            dec_legal;
    logic            launched_done;
    logic [DW-1:0]   launched_result;
    logic            timeout_hit;
    logic            accept;

    onehot_op_decoder u_decoder (
        .onehot (i_op),
        .op     (dec_op),
        .legal  (dec_legal)
    );

    assign accept = (state == IDLE) && i_start;

    // o_op only changes on a legal accept, so it names the launched unit in WAIT.
    always_comb begin
        launched_done   = 1'b0;
        launched_result = '0;
        case (o_op)
            OP_MULT: begin launched_done = i_unit_done[0]; launched_result = i_mult_result; end
            OP_DIV:  begin launched_done = i_unit_done[1]; launched_result = i_div_result;  end
            OP_ROOT: begin launched_done = i_unit_done[2]; launched_result = i_root_result; end
            default: ;
        endcase
    end

`ifdef OP_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_count;

    assign timeout_hit = (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst)                wd_count <= '0;
        else if (state == LAUNCH) wd_count <= '0;
        else if (state == WAIT)   wd_count <= wd_count + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (!dec_legal)            next_state = ERROR;
                    else if (dec_op == OP_NON) next_state = DONE;
                    else                       next_state = LAUNCH;
                end
            end
            LAUNCH:  next_state = WAIT;
            WAIT: begin
                if (launched_done)    next_state = DONE;
                else if (timeout_hit) next_state = ERROR;
            end
            DONE:    next_state = IDLE;
            ERROR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_unit_start <= '0;
            o_unit_x     <= '0;
            o_unit_y     <= '0;
            o_result     <= '0;
            o_op         <= OP_NON;
            o_valid      <= 1'b0;
            o_error      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_unit_start <= '0;
            o_valid      <= (next_state == DONE);
            o_error      <= (next_state == ERROR);
            o_busy       <= (next_state != IDLE);

            if (accept) begin
                o_unit_x <= i_data_x;
                o_unit_y <= i_data_y;
                if (dec_legal) begin
                    o_op <= dec_op;
                    if (dec_op == OP_NON) o_result     <= i_data_x;
                    else                  o_unit_start <= i_op[2:0];
                end
            end

            if (state == WAIT && launched_done) o_result <= launched_result;
            if (next_state == ERROR)            o_result <= '0;
        end
    end

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed self-checking bench for op_dispatcher; the timeout cases run only
// when OP_DISPATCH_TIMEOUT_EN is defined.
module tb_op_dispatcher;
    import pkg_system_mdr::*;

    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [3:0]    i_op;
    logic [DW-1:0] i_data_x, i_data_y;
    logic [2:0]    o_unit_start;
    logic [DW-1:0] o_unit_x, o_unit_y;
    logic [2:0]    i_unit_done;
    logic [DW-1:0] i_mult_result, i_div_result, i_root_result;
    logic [DW-1:0] o_result;
    op_select_t    o_op;
    logic          o_valid, o_error, o_busy;

    int checks = 0;
    int errors = 0;

    op_dispatcher #(.DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_data_x      (i_data_x),
        .i_data_y      (i_data_y),
        .o_unit_start  (o_unit_start),
        .o_unit_x      (o_unit_x),
        .o_unit_y      (o_unit_y),
        .i_unit_done   (i_unit_done),
        .i_mult_result (i_mult_result),
        .i_div_result  (i_div_result),
        .i_root_result (i_root_result),
        .o_result      (o_result),
        .o_op          (o_op),
        .o_valid       (o_valid),
        .o_error       (o_error),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [3:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
        i_start  = 1'b1;
        i_op     = op;
        i_data_x = x;
        i_data_y = y;
        tick();
        i_start  = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".start"},  32'(o_unit_start), 32'h0);
        check({tag, ".ux"},     32'(o_unit_x),     32'h0);
        check({tag, ".uy"},     32'(o_unit_y),     32'h0);
        check({tag, ".result"}, 32'(o_result),     32'h0);
        check({tag, ".op"},     32'(o_op),         32'(OP_NON));
        check({tag, ".valid"},  32'(o_valid),      32'h0);
        check({tag, ".error"},  32'(o_error),      32'h0);
        check({tag, ".busy"},   32'(o_busy),       32'h0);
    endtask

    initial begin
        rst = 1'b0; i_start = 1'b0; i_op = 4'b0; i_data_x = '0; i_data_y = '0;
        i_unit_done = 3'b0; i_mult_result = '0; i_div_result = '0; i_root_result = '0;
        tick(); tick();
        check_idle_reset("reset");
        rst = 1'b1;
        tick();

        // MULT: 3 * 4, done on the first WAIT cycle
        start_req(4'b0001, 16'h0003, 16'h0004);
        check("mult.launch_start", 32'(o_unit_start), 32'h1);
        check("mult.launch_busy",  32'(o_busy),       32'h1);
        check("mult.ux",           32'(o_unit_x),     32'h0003);
        check("mult.uy",           32'(o_unit_y),     32'h0004);
        check("mult.op",           32'(o_op),         32'(OP_MULT));
        tick();
        check("mult.wait_start",   32'(o_unit_start), 32'h0);
        check("mult.wait_valid",   32'(o_valid),      32'h0);
        i_unit_done = 3'b001; i_mult_result = 16'h000C;
        tick();
        i_unit_done = 3'b000;
        check("mult.valid",        32'(o_valid),      32'h1);
        check("mult.result",       32'(o_result),     32'h000C);
        tick();
        check("mult.valid_pulse",  32'(o_valid),      32'h0);
        check("mult.idle_busy",    32'(o_busy),       32'h0);
        check("mult.result_hold",  32'(o_result),     32'h000C);

        // Illegal ops: o_op keeps MULT, result cleared
        start_req(4'b0000, 16'h1111, 16'h2222);
        check("ill0.error",  32'(o_error),      32'h1);
        check("ill0.result", 32'(o_result),     32'h0);
        check("ill0.start",  32'(o_unit_start), 32'h0);
        check("ill0.op",     32'(o_op),         32'(OP_MULT));
        tick();
        check("ill0.error_pulse", 32'(o_error), 32'h0);
        start_req(4'b0110, 16'h3333, 16'h4444);
        check("ill6.error",  32'(o_error),      32'h1);
        check("ill6.result", 32'(o_result),     32'h0);
        check("ill6.start",  32'(o_unit_start), 32'h0);
        check("ill6.op",     32'(o_op),         32'(OP_MULT));
        tick();

        // NON pass-through
        start_req(4'b1000, 16'hBEEF, 16'h0001);
        check("non.valid",  32'(o_valid),      32'h1);
        check("non.result", 32'(o_result),     32'hBEEF);
        check("non.start",  32'(o_unit_start), 32'h0);
        check("non.op",     32'(o_op),         32'(OP_NON));
        tick();
        check("non.idle",   32'(o_busy),       32'h0);

        // DIV with spurious done (MULT bit) and start during WAIT
        start_req(4'b0010, 16'h000A, 16'h0002);
        check("div.start", 32'(o_unit_start), 32'h2);
        tick();
        i_unit_done = 3'b001; i_start = 1'b1; i_op = 4'b0001; i_mult_result = 16'h00FF;
        tick();
        i_unit_done = 3'b000; i_start = 1'b0;
        check("div.spur_valid", 32'(o_valid),      32'h0);
        check("div.spur_busy",  32'(o_busy),       32'h1);
        check("div.spur_start", 32'(o_unit_start), 32'h0);
        check("div.spur_op",    32'(o_op),         32'(OP_DIV));
        i_unit_done = 3'b010; i_div_result = 16'h0005;
        tick();
        i_unit_done = 3'b000;
        check("div.valid",  32'(o_valid),  32'h1);
        check("div.result", 32'(o_result), 32'h0005);
        tick();

        // ROOT: done in LAUNCH ignored, then reset mid-WAIT
        start_req(4'b0100, 16'h0031, 16'h0000);
        check("root.start", 32'(o_unit_start), 32'h4);
        i_unit_done = 3'b100; i_root_result = 16'h0007;
        tick();
        i_unit_done = 3'b000;
        check("root.launch_done_valid", 32'(o_valid), 32'h0);
        check("root.in_wait_busy",      32'(o_busy),  32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle_reset("midrst");
        i_unit_done = 3'b100;
        tick();
        i_unit_done = 3'b000;
        check("midrst.late_done_valid",  32'(o_valid),  32'h0);
        check("midrst.late_done_result", 32'(o_result), 32'h0);
        check("midrst.late_done_busy",   32'(o_busy),   32'h0);
        start_req(4'b1000, 16'h1234, 16'h0000);
        check("midrst.new_valid",  32'(o_valid),  32'h1);
        check("midrst.new_result", 32'(o_result), 32'h1234);
        tick();

`ifdef OP_DISPATCH_TIMEOUT_EN
        // No done: error after TO WAIT cycles
        start_req(4'b0001, 16'h0002, 16'h0002);
        for (int i = 0; i < TO; i++) tick();
        check("to.before_error", 32'(o_error), 32'h0);
        check("to.before_busy",  32'(o_busy),  32'h1);
        tick();
        check("to.error",  32'(o_error),  32'h1);
        check("to.result", 32'(o_result), 32'h0);
        tick();
        // Done on the last WAIT cycle wins
        start_req(4'b0010, 16'h0008, 16'h0002);
        for (int i = 0; i < TO; i++) tick();
        i_unit_done = 3'b010; i_div_result = 16'h0004;
        tick();
        i_unit_done = 3'b000;
        check("to.edge_valid",  32'(o_valid),  32'h1);
        check("to.edge_error",  32'(o_error),  32'h0);
        check("to.edge_result", 32'(o_result), 32'h0004);
        tick();
`else
        // Without the watchdog, WAIT holds well past any timeout window
        start_req(4'b0001, 16'h0002, 16'h0002);
        for (int i = 0; i < 3 * TO; i++) tick();
        check("hold.busy",  32'(o_busy),  32'h1);
        check("hold.error", 32'(o_error), 32'h0);
        check("hold.valid", 32'(o_valid), 32'h0);
        i_unit_done = 3'b001; i_mult_result = 16'h0004;
        tick();
        i_unit_done = 3'b000;
        check("hold.valid_late",  32'(o_valid),  32'h1);
        check("hold.result_late", 32'(o_result), 32'h0004);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/op_dispatcher.md
# op_dispatcher

Consumer end of the one-hot operation select bus in the MDR system. Accepts the 4-bit one-hot operation code plus operands, validates it, launches exactly one arithmetic unit (multiplier, divider, square root) or passes operand X through for NON, waits for that unit's done, and returns the result with the operation re-encoded as `op_select_t`. Sits between the op selector and the three datapath units.

## Interface

- `DW`, 16, operand/result width
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT (used only with `OP_DISPATCH_TIMEOUT_EN`)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `i_start`  in  1  request strobe; sampled only in IDLE
- `i_op`  in  4  one-hot op: bit0 MULT, bit1 DIV, bit2 ROOT, bit3 NON
- `i_data_x`  in  DW  operand X
- `i_data_y`  in  DW  operand Y
- `o_unit_start`  out  3  one-hot start pulse to MULT/DIV/ROOT unit
- `o_unit_x`, `o_unit_y`  out  DW each  latched operands to units
- `i_unit_done`  in  3  done flags from MULT/DIV/ROOT units
- `i_mult_result`, `i_div_result`, `i_root_result`  in  DW each  unit results
- `o_result`  out  DW  captured result
- `o_op`  out  `op_select_t`  operation of the last accepted request
- `o_valid`  out  1  one-cycle pulse: `o_result` valid
- `o_error`  out  1  one-cycle pulse: illegal op or timeout
- `o_busy`  out  1  high in every state except IDLE

## Operation

- States: IDLE, LAUNCH, WAIT, DONE, ERROR.
- IDLE: `o_busy`=0. On `i_start`=1, latch `i_data_x`/`i_data_y` and `i_op`:
  - exactly one of bits 0–2 set → LAUNCH; `o_op` = MULT/DIV/ROOT.
  - `i_op`=4'b1000 → `o_result` = `i_data_x`, `o_op` = NON, go DONE.
  - `i_op`=0 or more than one bit set → ERROR; `o_op` unchanged.
- LAUNCH (1 cycle): drive `o_unit_start` bit matching latched op; go WAIT.
- WAIT: sample only the done bit of the launched unit; other done bits ignored. On done: capture that unit's result into `o_result`, go DONE.
- DONE (1 cycle): `o_valid`=1; go IDLE.
- ERROR (1 cycle): `o_error`=1, `o_result` cleared to 0; go IDLE.
- `i_start` outside IDLE ignored (no queuing). `i_unit_done` outside WAIT ignored, including in LAUNCH.
- `o_result` and `o_op` hold between requests.
- Reset (any state, mid-operation included): state IDLE; `o_unit_start`=0, `o_unit_x`/`o_unit_y`=0, `o_result`=0, `o_op`=NON, `o_valid`=0, `o_error`=0, `o_busy`=0, watchdog counter 0.

## Timing

- Start sampled at edge 0 → LAUNCH in cycle 1 (`o_unit_start` high exactly one cycle) → WAIT from cycle 2.
- Done sampled at edge k (in WAIT) → `o_valid` high in cycle k+1; minimum MULT/DIV/ROOT latency start→valid = 3 cycles (done asserted first WAIT cycle).
- NON: start at edge 0 → `o_valid` in cycle 1. Illegal op: `o_error` in cycle 1.
- Back-to-back: next `i_start` accepted the cycle after DONE/ERROR (IDLE).
- All outputs registered; no combinational input→output paths.

## Configuration

- `OP_DISPATCH_TIMEOUT_EN` defined: counter cleared on WAIT entry, increments each WAIT cycle; if count reaches `TIMEOUT_CYCLES`-1 without done → ERROR. Done in the same cycle as the limit wins (DONE).
- Not defined: no counter; WAIT holds indefinitely until done; `TIMEOUT_CYCLES` unused.

## Structure

- `pkg_system_mdr` additions: `dispatch_state_t` enum (IDLE, LAUNCH, WAIT, DONE, ERROR), one-hot constants `OH_MULT`=4'b0001, `OH_DIV`=4'b0010, `OH_ROOT`=4'b0100, `OH_NON`=4'b1000. Reuse existing `op_select_t`.
- One sub-module: `onehot_op_decoder` — combinational, 4-bit one-hot → `op_select_t` plus `legal` flag; instantiated once in IDLE decode path.

## Test plan

- Reset then MULT: `i_op`=4'b0001, X=16'h0003, Y=16'h0004, done 2 cycles after start with `i_mult_result`=16'h000C → `o_unit_start`=3'b001 one cycle, `o_valid` one cycle, `o_result`=16'h000C, `o_op`=MULT.
- NON pass-through: `i_op`=4'b1000, X=16'hBEEF → `o_valid` cycle after start, `o_result`=16'hBEEF, `o_unit_start` never asserted.
- Illegal ops: `i_op`=4'b0000 then 4'b0110 → `o_error` pulse each, `o_result`=0, no unit start, `o_op` unchanged.
- Spurious done/start: in DIV WAIT, pulse `i_unit_done`=3'b001 and `i_start`=1 → ignored; then `i_unit_done`=3'b010 with `i_div_result`=16'h0005 → `o_result`=16'h0005.
- Reset mid-WAIT (ROOT launched, `rst`=0 one cycle) → all outputs at reset values next cycle, later ROOT done ignored, new request accepted.
- With `OP_DISPATCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no done → `o_error` after 8 WAIT cycles; done on 8th WAIT cycle → `o_valid` instead.
